// File: rtl/core_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : core_control_fsm
//  Purpose  : Multi-cycle instruction sequencer for the Core101 RV32I
//             datapath (FETCH/DECODE/EXECUTE/MEM/WB) with memory handshake,
//             datapath strobes, illegal-opcode and memory-timeout trapping.
//  Revision : 1.0 - initial release
// ============================================================================
module core_control_fsm #(
    parameter int MEM_TIMEOUT = 16          // 2..255 cycles without mem_ready
) (
    input  logic       core_control_clock,
    input  logic       core_control_reset,
    input  logic       core_control_start,
    input  logic [6:0] core_control_opcode,
    input  logic       core_control_mem_ready,
    output logic       core_control_mem_req,
    output logic       core_control_mem_we,
    output logic       core_control_ir_load,
    output logic       core_control_pc_write,
    output logic       core_control_rf_write,
    output logic [1:0] core_control_wb_sel,
    output logic [3:0] core_control_state,
    output logic       core_control_busy,
    output logic       core_control_trap
);

    typedef enum logic [3:0] {
        S_HALT    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXECUTE = 4'd3,
        S_MEM     = 4'd4,
        S_WB      = 4'd5,
        S_TRAP    = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    localparam logic [1:0] c_WB_ALU = 2'b00;
    localparam logic [1:0] c_WB_MEM = 2'b01;
    localparam logic [1:0] c_WB_PC4 = 2'b10;

    // Last wait-cycle count before an unanswered request traps.
    localparam logic [7:0] c_TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_opcode;
    logic [7:0] r_tmo_cnt;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_ir_load;
    logic       w_pc_write;
    logic       w_rf_write;
    logic [1:0] w_wb_sel;
    logic       w_trap;
    logic       w_tmo_hit;

    function automatic logic f_is_legal(input logic [6:0] op);
        logic v;
        case (op)
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_BRANCH,
            c_OP_LOAD, c_OP_STORE, c_OP_IMM, c_OP_OP: v = 1'b1;
            default:                                  v = 1'b0;
        endcase
        return v;
    endfunction

    // Final wait cycle reached with the memory still silent.
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST) && !core_control_mem_ready;

    // State, latched opcode and memory wait counter.
    always_ff @(posedge core_control_clock) begin
        if (core_control_reset) begin
            r_state   <= S_HALT;
            r_opcode  <= 7'd0;
            r_tmo_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= core_control_opcode;
            end
            // Clear on entry to a memory-access state; count unanswered cycles.
            if ((w_next == S_FETCH || w_next == S_MEM) && (w_next != r_state)) begin
                r_tmo_cnt <= 8'd0;
            end else if (w_mem_req && !core_control_mem_ready) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    // Next-state and per-cycle strobe decode from state, opcode and mem_ready.
    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_ir_load  = 1'b0;
        w_pc_write = 1'b0;
        w_rf_write = 1'b0;
        w_wb_sel   = c_WB_ALU;
        w_trap     = 1'b0;
        case (r_state)
            S_HALT: begin
                if (core_control_start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (core_control_mem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_tmo_hit) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                w_next = f_is_legal(core_control_opcode) ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (r_opcode == c_OP_LOAD || r_opcode == c_OP_STORE) begin
                    w_next = S_MEM;
                end else if (r_opcode == c_OP_BRANCH) begin
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (r_opcode == c_OP_STORE);
                if (core_control_mem_ready) begin
                    if (r_opcode == c_OP_STORE) begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_tmo_hit) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                w_rf_write = 1'b1;
                w_pc_write = 1'b1;
                if (r_opcode == c_OP_LOAD) begin
                    w_wb_sel = c_WB_MEM;
                end else if (r_opcode == c_OP_JAL || r_opcode == c_OP_JALR) begin
                    w_wb_sel = c_WB_PC4;
                end else begin
                    w_wb_sel = c_WB_ALU;
                end
                w_next = S_FETCH;
            end
            S_TRAP: begin
                w_trap = 1'b1;
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    assign core_control_mem_req  = w_mem_req;
    assign core_control_mem_we   = w_mem_we;
    assign core_control_ir_load  = w_ir_load;
    assign core_control_pc_write = w_pc_write;
    assign core_control_rf_write = w_rf_write;
    assign core_control_wb_sel   = w_wb_sel;
    assign core_control_state    = r_state;
    assign core_control_busy     = (r_state != S_HALT) && (r_state != S_TRAP);
    assign core_control_trap     = w_trap;

endmodule
`default_nettype wire

// File: tb/tb_core_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_control_fsm
//  Purpose  : Self-checking bench for core_control_fsm. Each instruction is
//             expanded into its expected per-cycle trace (state code, strobes,
//             inputs to drive) from the instruction-level rules, then played.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_control_fsm;

    localparam int T = 16;

    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP     = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] opcode;
    logic       ready;
    logic       mem_req, mem_we, ir_load, pc_write, rf_write, busy, trap;
    logic [1:0] wb_sel;
    logic [3:0] state;

    core_control_fsm #(.MEM_TIMEOUT(T)) dut (
        .core_control_clock     (clk),
        .core_control_reset     (rst),
        .core_control_start     (start),
        .core_control_opcode    (opcode),
        .core_control_mem_ready (ready),
        .core_control_mem_req   (mem_req),
        .core_control_mem_we    (mem_we),
        .core_control_ir_load   (ir_load),
        .core_control_pc_write  (pc_write),
        .core_control_rf_write  (rf_write),
        .core_control_wb_sel    (wb_sel),
        .core_control_state     (state),
        .core_control_busy      (busy),
        .core_control_trap      (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       req;
        logic       we;
        logic       irl;
        logic       pcw;
        logic       rfw;
        logic [1:0] wbs;
        logic       sin;
        logic [6:0] op;
    } ent_t;

    ent_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [6:0] cur_op = 7'd0;
    logic [6:0] legal [9] = '{c_LUI, c_AUIPC, c_JAL, c_JALR, c_BRANCH,
                              c_LOAD, c_STORE, c_IMM, c_OP};

    function automatic logic rs();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        foreach (legal[i]) if (legal[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic req,
                        input logic we, input logic irl, input logic pcw,
                        input logic rfw, input logic [1:0] wbs, input logic sin);
        ent_t e;
        e.st = st; e.rdy = rdy; e.req = req; e.we = we; e.irl = irl;
        e.pcw = pcw; e.rfw = rfw; e.wbs = wbs; e.sin = sin; e.op = cur_op;
        q.push_back(e);
    endtask

    // A memory access: 'waits' silent cycles then completion, or a timeout.
    task automatic access(input logic [3:0] st, input int waits, input logic we,
                          input logic irl_done, input logic pcw_done, output bit to);
        int n;
        n  = (waits >= T) ? T : waits;
        to = (waits >= T);
        for (int i = 0; i < n; i++) push(st, 1'b0, 1'b1, we, 1'b0, 1'b0, 1'b0, 2'b00, rs());
        if (!to) push(st, 1'b1, 1'b1, we, irl_done, pcw_done, 1'b0, 2'b00, rs());
    endtask

    // Expected trace of one instruction from FETCH onward.
    task automatic gen_instr(input logic [6:0] op, input int wf, input int wm, output bit trapped);
        bit         to;
        bit         ld, stq, br;
        logic [1:0] wbs;
        ld  = (op == c_LOAD);
        stq = (op == c_STORE);
        br  = (op == c_BRANCH);
        wbs = ld ? 2'b01 : ((op == c_JAL || op == c_JALR) ? 2'b10 : 2'b00);
        cur_op  = op;
        trapped = 1'b0;
        access(4'd1, wf, 1'b0, 1'b1, 1'b0, to);
        if (to) begin trapped = 1'b1; return; end
        push(4'd2, rs(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rs());
        if (!is_legal(op)) begin trapped = 1'b1; return; end
        push(4'd3, rs(), 1'b0, 1'b0, 1'b0, br, 1'b0, 2'b00, rs());
        if (br) return;
        if (ld || stq) begin
            access(4'd4, wm, stq, 1'b0, stq, to);
            if (to) begin trapped = 1'b1; return; end
            if (stq) return;
        end
        push(4'd5, rs(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, wbs, rs());
    endtask

    task automatic push_trap(input int n);
        for (int i = 0; i < n; i++) push(4'd15, rs(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    endtask

    task automatic push_start();
        push(4'd0, rs(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    endtask

    // Drive each expected cycle's inputs, compare at the falling edge.
    task automatic run_queue(input int limit);
        int left;
        left = limit;
        while (q.size() > 0 && left > 0) begin
            ent_t       e;
            logic [3:0] es;
            e  = q.pop_front();
            es = e.st;
            ready  = e.rdy;
            start  = e.sin;
            opcode = e.op;
            @(negedge clk);
            chk($sformatf("cycle_state%0d_op%b", es, e.op),
                {19'd0, state, mem_req, mem_we, ir_load, pc_write, rf_write, wb_sel, busy, trap},
                {19'd0, es, e.req, e.we, e.irl, e.pcw, e.rfw, e.wbs,
                 (es != 4'd0 && es != 4'd15), (es == 4'd15)});
            @(posedge clk);
            #1;
            left--;
        end
    endtask

    task automatic do_reset(input string tag);
        rst   = 1'b1;
        start = rs();
        ready = rs();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk(tag, {19'd0, state, mem_req, mem_we, ir_load, pc_write, rf_write, wb_sel, busy, trap}, 32'd0);
    endtask

    initial begin
        bit   tr;
        bit   running;
        logic [6:0] op;
        int   wf, wm;

        rst = 1'b1; start = 1'b0; ready = 1'b0; opcode = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_state", {19'd0, state, mem_req, mem_we, ir_load, pc_write, rf_write, wb_sel, busy, trap}, 32'd0);

        // HALT holds without start, then a back-to-back directed program.
        push(4'd0, rs(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        push_start();
        gen_instr(c_OP, 0, 0, tr);
        gen_instr(c_OP, 0, 0, tr);
        gen_instr(c_LOAD, 0, 3, tr);
        gen_instr(c_STORE, 0, 2, tr);
        gen_instr(c_BRANCH, 0, 0, tr);
        gen_instr(c_JAL, 1, 0, tr);
        gen_instr(c_JALR, 0, 0, tr);
        gen_instr(c_LUI, 0, 0, tr);
        run_queue(1000);

        // Illegal opcode traps; start ignored; reset recovers.
        gen_instr(7'b1111111, 0, 0, tr);
        push_trap(3);
        run_queue(1000);
        do_reset("reset_from_trap");

        // Fetch timeout on the T-th silent cycle.
        push_start();
        gen_instr(c_OP, T, 0, tr);
        push_trap(2);
        run_queue(1000);
        do_reset("reset_after_fetch_timeout");

        // Ready on the last allowed cycle completes normally.
        push_start();
        gen_instr(c_OP, T - 1, 0, tr);
        run_queue(1000);

        // Reset in the middle of a data access.
        gen_instr(c_LOAD, 0, 10, tr);
        run_queue(5);
        q.delete();
        do_reset("reset_mid_mem");

        // Data-side timeout on a store.
        push_start();
        gen_instr(c_STORE, 0, T, tr);
        push_trap(2);
        run_queue(1000);
        do_reset("reset_after_mem_timeout");

        // Randomized instruction stream.
        running = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (!running) push_start();
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else op = legal[$urandom_range(0, 8)];
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
            gen_instr(op, wf, wm, tr);
            if (tr) begin
                push_trap(2);
                run_queue(1000);
                do_reset("reset_random_trap");
                running = 1'b0;
            end else begin
                run_queue(1000);
                running = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_control_fsm.md
Name: core_control_fsm

Overview:
- Multi-cycle control unit for the Core101 RV32I datapath.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WB using a 4-bit state register.
- Issues instruction/data memory handshakes and per-cycle datapath strobes: IR load, PC write, register-file write, write-back select.
- Traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles mem_req may stay asserted without mem_ready before trapping (2..255).

Ports:
- core_control_clock  in  1  sole clock; all state updates on rising edge.
- core_control_reset  in  1  synchronous, active-high reset.
- core_control_start  in  1  leave HALT and begin fetching.
- core_control_opcode  in  7  IR[6:0] from datapath; sampled in DECODE.
- core_control_mem_ready  in  1  memory completes the current request this cycle.
- core_control_mem_req  out  1  memory request (fetch or data).
- core_control_mem_we  out  1  write enable qualifying mem_req (stores only).
- core_control_ir_load  out  1  load instruction register.
- core_control_pc_write  out  1  update PC; datapath selects the next-PC source.
- core_control_rf_write  out  1  register-file write enable.
- core_control_wb_sel  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4.
- core_control_state  out  4  current state, for debug.
- core_control_busy  out  1  high when state is not HALT and not TRAP.
- core_control_trap  out  1  sticky error flag.

Behaviour:
- Reset: applied on the clock edge with reset=1, regardless of current state or pending memory request.
  - State becomes HALT, latched opcode = 0, timeout counter = 0.
  - All outputs read 0, including trap.
- State encoding: HALT=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=15. Codes 6..14 are unreachable and go to TRAP.
- Outputs are combinational from the registered state, the latched opcode and mem_ready. ir_load, pc_write and rf_write are strobes lasting exactly one cycle.
- HALT: start=1 moves to FETCH; start is ignored in every other state.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready=1: ir_load=1 in the same cycle, then go to DECODE.
- DECODE: one cycle; latch the opcode.
  - Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Legal opcode goes to EXECUTE; anything else goes to TRAP.
- EXECUTE: one cycle.
  - LOAD or STORE goes to MEM.
  - BRANCH: pc_write=1, then FETCH.
  - All other opcodes go to WB.
- MEM:
  - mem_req=1; mem_we=1 only for STORE.
  - On mem_ready: STORE asserts pc_write=1 and goes to FETCH; LOAD goes to WB.
- WB: rf_write=1 and pc_write=1, then FETCH.
  - wb_sel=01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - wb_sel is 00 in every state other than WB.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 with mem_ready=0.
  - When the counter reaches MEM_TIMEOUT-1 with mem_ready still 0, the next state is TRAP and mem_req drops.
  - mem_ready arriving on that final cycle still completes the access normally.
- TRAP: trap=1 and all strobes 0. Held until reset; start has no effect.
- mem_req stays stable from assertion until mem_ready, except on reset or timeout. mem_ready outside FETCH/MEM is ignored.
- Zero-wait latency in cycles: ALU/LUI/AUIPC/JAL/JALR 4; BRANCH 3; STORE 4; LOAD 5. Each wait cycle adds one.

Test Plan:
- Reset, then start=1 for one cycle, opcode=0110011, mem_ready=1 always -> state sequence 0,1,2,3,5,1.
  - ir_load in cycle FETCH; rf_write=1, pc_write=1, wb_sel=00 in WB.
  - Exactly 4 cycles per instruction.
- LOAD (0000011) with data mem_ready delayed 3 cycles -> MEM holds mem_req=1, mem_we=0 for 4 cycles, then WB with wb_sel=01, rf_write=1.
- STORE (0100011) -> MEM asserts mem_req=1, mem_we=1; on ready, pc_write=1 and next state FETCH; rf_write never asserted.
- BRANCH (1100011) -> pc_write pulses in EXECUTE, then FETCH; total 3 cycles; rf_write stays 0.
- Opcode 1111111 -> TRAP (state=15, trap=1, busy=0); start=1 is ignored; reset=1 returns to HALT with trap=0.
- FETCH with mem_ready=0 for 16 cycles (MEM_TIMEOUT=16) -> TRAP on cycle 17 and mem_req drops.
  - Repeat with ready on cycle 16 -> normal DECODE.
  - Assert reset mid-MEM -> HALT and mem_req=0 after the edge.
